// File: rtl/nf_wb_arbiter_if.sv
// Bus bundle for nf_wb_arbiter: execute/LSU inputs on one side,
// register file write port plus load-queue status on the other.
interface nf_wb_arbiter_if;
  logic        alu_we;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        ld_req;
  logic [4:0]  ld_wa;
  logic        lsu_valid;
  logic [31:0] lsu_rdata;
  logic        ld_full;
  logic [31:0] pending_mask;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        we3;
  logic        err;

  modport master (
    output alu_we, alu_wa, alu_wd, ld_req, ld_wa, lsu_valid, lsu_rdata,
    input  ld_full, pending_mask, wa3, wd3, we3, err
  );

  modport slave (
    input  alu_we, alu_wa, alu_wd, ld_req, ld_wa, lsu_valid, lsu_rdata,
    output ld_full, pending_mask, wa3, wd3, we3, err
  );
endinterface

// File: rtl/nf_wb_arbiter.sv
// Write-back arbiter: ALU results take the register file write port first, in-order loads
// drain from an ordered queue. Define NF_WB_BYPASS_EN to launch a load response straight to the port.
module nf_wb_arbiter #(
  parameter int LQ_DEPTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  nf_wb_arbiter_if.slave bus
);
  localparam int IW = $clog2(LQ_DEPTH);
  localparam int PW = IW + 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t tail_q, tail_d, fill_q, fill_d, head_q, head_d, cnt;
  logic [LQ_DEPTH-1:0][4:0]  wa_q, wa_d;
  logic [LQ_DEPTH-1:0][31:0] data_q, data_d;
  logic [LQ_DEPTH-1:0]       filled_q, filled_d;
  logic        we3_q, we3_d, ld_src_q, ld_src_d, err_q, err_d;
  logic [4:0]  wa3_q, wa3_d;
  logic [31:0] wd3_q, wd3_d;
  logic        ld_full, alloc, fill_ok, drain, bypass;
  logic [IW-1:0] hidx, tidx, fidx, off;
  logic [31:0] pending;

  always_comb begin
    tail_d   = tail_q;
    fill_d   = fill_q;
    head_d   = head_q;
    wa_d     = wa_q;
    data_d   = data_q;
    filled_d = filled_q;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    ld_src_d = ld_src_q;
    we3_d    = 1'b0;
    hidx     = head_q[IW-1:0];
    tidx     = tail_q[IW-1:0];
    fidx     = fill_q[IW-1:0];
    cnt      = tail_q - head_q;
    ld_full  = (cnt == ptr_t'(LQ_DEPTH));
    alloc    = bus.ld_req && !ld_full;
    fill_ok  = bus.lsu_valid && (fill_q != tail_q);
    drain    = !bus.alu_we && filled_q[hidx];
`ifdef NF_WB_BYPASS_EN
    bypass   = fill_ok && !bus.alu_we && (fill_q == head_q) && !filled_q[hidx];
`else
    bypass   = 1'b0;
`endif
    err_d    = err_q | (bus.ld_req && ld_full) | (bus.lsu_valid && (fill_q == tail_q));

    if (alloc) begin
      wa_d[tidx]     = bus.ld_wa;
      filled_d[tidx] = 1'b0;
      tail_d         = tail_q + ptr_t'(1);
    end

    if (fill_ok) begin
      fill_d = fill_q + ptr_t'(1);
      if (!bypass) begin
        data_d[fidx]   = bus.lsu_rdata;
        filled_d[fidx] = 1'b1;
      end
    end

    // r0 destinations still occupy a launch slot, they just never raise we3
    if (bus.alu_we) begin
      we3_d    = |bus.alu_wa;
      wa3_d    = bus.alu_wa;
      wd3_d    = bus.alu_wd;
      ld_src_d = 1'b0;
    end else if (drain || bypass) begin
      we3_d          = |wa_q[hidx];
      wa3_d          = wa_q[hidx];
      wd3_d          = bypass ? bus.lsu_rdata : data_q[hidx];
      ld_src_d       = 1'b1;
      filled_d[hidx] = 1'b0;
      head_d         = head_q + ptr_t'(1);
    end
  end

  // A load's bit stays up through its we3 cycle so readers see it until the RF holds the data
  always_comb begin
    pending = '0;
    off     = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      off = IW'(i) - head_q[IW-1:0];
      if (({1'b0, off} < cnt) && (wa_q[i] != 5'd0))
        pending[wa_q[i]] = 1'b1;
    end
    if (we3_q && ld_src_q)
      pending[wa3_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tail_q   <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      wa_q     <= '0;
      data_q   <= '0;
      filled_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      ld_src_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      wa_q     <= wa_d;
      data_q   <= data_d;
      filled_q <= filled_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      ld_src_q <= ld_src_d;
      err_q    <= err_d;
    end
  end

  assign bus.ld_full      = ld_full;
  assign bus.pending_mask = pending;
  assign bus.we3          = we3_q;
  assign bus.wa3          = wa3_q;
  assign bus.wd3          = wd3_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_nf_wb_arbiter.sv
// Directed bench for nf_wb_arbiter: expected RF writes go into a scoreboard queue,
// a negedge monitor pops and compares every we3 pulse.
module tb_nf_wb_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_q[$];

  nf_wb_arbiter_if bif();

  nf_wb_arbiter #(.LQ_DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] wa, input logic [31:0] wd);
    wr_t w;
    w.wa = wa;
    w.wd = wd;
    exp_q.push_back(w);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bif.we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write r%0d=%h expected none", bif.wa3, bif.wd3);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("sb_wa3", {27'd0, bif.wa3}, {27'd0, w.wa});
        chk("sb_wd3", bif.wd3, w.wd);
      end
    end
  end

  logic [31:0] resp [4];
  bit seen_c, cleared;

  initial begin
    bif.alu_we = 0; bif.alu_wa = 0; bif.alu_wd = 0;
    bif.ld_req = 0; bif.ld_wa = 0;
    bif.lsu_valid = 0; bif.lsu_rdata = 0;
    resetn = 0;
    cyc(); cyc();
    resetn = 1;
    chk("rst_we3", {31'd0, bif.we3}, 32'd0);
    chk("rst_wa3", {27'd0, bif.wa3}, 32'd0);
    chk("rst_wd3", bif.wd3, 32'd0);
    chk("rst_pend", bif.pending_mask, 32'd0);
    chk("rst_full", {31'd0, bif.ld_full}, 32'd0);
    chk("rst_err", {31'd0, bif.err}, 32'd0);

    // 1: ALU single-cycle write
    bif.alu_we = 1; bif.alu_wa = 5; bif.alu_wd = 32'h1234;
    push(5, 32'h1234);
    cyc();
    bif.alu_we = 0;
    chk("t1_we3_n1", {31'd0, bif.we3}, 32'd1);
    chk("t1_pend", bif.pending_mask, 32'd0);
    cyc();
    chk("t1_we3_n2", {31'd0, bif.we3}, 32'd0);

    // 2: single load to r7
    bif.ld_req = 1; bif.ld_wa = 7;
    push(7, 32'hDEADBEEF);
    cyc();
    bif.ld_req = 0;
    chk("t2_pend_set", bif.pending_mask, 32'h80);
    cyc();
    bif.lsu_valid = 1; bif.lsu_rdata = 32'hDEADBEEF;
    cyc();
    bif.lsu_valid = 0;
`ifndef NF_WB_BYPASS_EN
    chk("t2_we3_fill1", {31'd0, bif.we3}, 32'd0);
    cyc();
`endif
    chk("t2_we3", {31'd0, bif.we3}, 32'd1);
    chk("t2_pend_hold", bif.pending_mask, 32'h80);
    cyc();
    chk("t2_we3_off", {31'd0, bif.we3}, 32'd0);
    chk("t2_pend_clr", bif.pending_mask, 32'd0);

    // 3: ALU starves a filled load
    bif.ld_req = 1; bif.ld_wa = 3;
    cyc();
    bif.ld_req = 0;
    for (int k = 0; k < 3; k++) begin
      bif.alu_we = 1; bif.alu_wa = 9; bif.alu_wd = 32'h901 + k;
      push(9, 32'h901 + k);
      bif.lsu_valid = (k == 0); bif.lsu_rdata = 32'h33;
      cyc();
      chk("t3_pend3", {31'd0, bif.pending_mask[3]}, 32'd1);
    end
    bif.alu_we = 0; bif.lsu_valid = 0;
    push(3, 32'h33);
    cyc();
    chk("t3_ld_we3", {31'd0, bif.we3}, 32'd1);
    chk("t3_pend_during", bif.pending_mask, 32'h8);
    cyc();
    chk("t3_pend_clr", bif.pending_mask, 32'd0);

    // 4: fill the queue, overflow, then drain incl. an r0 entry
    for (int k = 0; k < 4; k++) begin
      bif.ld_req = 1;
      bif.ld_wa = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : (k == 2) ? 5'd1 : 5'd0;
      cyc();
    end
    chk("t4_full", {31'd0, bif.ld_full}, 32'd1);
    chk("t4_pend", bif.pending_mask, 32'h6);
    chk("t4_err_pre", {31'd0, bif.err}, 32'd0);
    bif.ld_wa = 5;
    cyc();
    bif.ld_req = 0;
    chk("t4_err_ovf", {31'd0, bif.err}, 32'd1);
    chk("t4_full_hold", {31'd0, bif.ld_full}, 32'd1);
    chk("t4_pend_noalloc", bif.pending_mask, 32'h6);
    resp[0] = 32'hAAAA0001; resp[1] = 32'hBBBB0002;
    resp[2] = 32'hCCCC0003; resp[3] = 32'hDDDD0004;
    push(1, resp[0]); push(2, resp[1]); push(1, resp[2]);
    seen_c = 0; cleared = 0;
    for (int k = 0; k < 10; k++) begin
      bif.lsu_valid = (k < 4);
      bif.lsu_rdata = (k < 4) ? resp[k] : 32'd0;
      cyc();
      if (bif.we3 && bif.wa3 == 5'd2)
        chk("t4_pend1_at_b", {31'd0, bif.pending_mask[1]}, 32'd1);
      if (seen_c && !cleared) begin
        chk("t4_pend1_after_c", {31'd0, bif.pending_mask[1]}, 32'd0);
        cleared = 1;
      end
      if (bif.we3 && bif.wa3 == 5'd1 && bif.wd3 == resp[2]) begin
        chk("t4_pend1_at_c", {31'd0, bif.pending_mask[1]}, 32'd1);
        seen_c = 1;
      end
    end
    chk("t4_c_written", {31'd0, cleared}, 32'd1);
    chk("t4_pend_end", bif.pending_mask, 32'd0);
    chk("t4_full_end", {31'd0, bif.ld_full}, 32'd0);
    chk("t4_err_sticky", {31'd0, bif.err}, 32'd1);

    // 5: response with empty queue
    resetn = 0; cyc(); resetn = 1;
    chk("t5_err_rst", {31'd0, bif.err}, 32'd0);
    bif.lsu_valid = 1; bif.lsu_rdata = 32'h55555555;
    cyc();
    bif.lsu_valid = 0;
    chk("t5_err", {31'd0, bif.err}, 32'd1);
    chk("t5_no_we3", {31'd0, bif.we3}, 32'd0);
    bif.ld_req = 1; bif.ld_wa = 4;
    push(4, 32'h44444444);
    cyc();
    bif.ld_req = 0;
    bif.lsu_valid = 1; bif.lsu_rdata = 32'h44444444;
    cyc();
    bif.lsu_valid = 0;
    cyc(); cyc(); cyc();
    chk("t5_pend_end", bif.pending_mask, 32'd0);

    // 6: reset with two loads outstanding, one filled and held off by ALU r0 writes
    bif.ld_req = 1; bif.ld_wa = 10;
    cyc();
    bif.ld_wa = 11;
    cyc();
    bif.ld_req = 0;
    bif.alu_we = 1; bif.alu_wa = 0; bif.alu_wd = 32'hFFFF;
    bif.lsu_valid = 1; bif.lsu_rdata = 32'h10101010;
    cyc();
    bif.lsu_valid = 0;
    chk("t6_r0_no_we3", {31'd0, bif.we3}, 32'd0);
    chk("t6_pend_pre", bif.pending_mask, 32'hC00);
    bif.alu_we = 0;
    resetn = 0;
    cyc();
    resetn = 1;
    chk("t6_we3", {31'd0, bif.we3}, 32'd0);
    chk("t6_pend", bif.pending_mask, 32'd0);
    chk("t6_full", {31'd0, bif.ld_full}, 32'd0);
    chk("t6_err", {31'd0, bif.err}, 32'd0);
    cyc();
    chk("t6_we3_idle", {31'd0, bif.we3}, 32'd0);
    bif.ld_req = 1; bif.ld_wa = 12;
    push(12, 32'hC0FFEE12);
    cyc();
    bif.ld_req = 0;
    bif.lsu_valid = 1; bif.lsu_rdata = 32'hC0FFEE12;
    cyc();
    bif.lsu_valid = 0;
    cyc(); cyc(); cyc(); cyc();
    chk("t6_pend_end", bif.pending_mask, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
